// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer and display chain.
// Provides the FSM state encoding, the BCD digit type and digit limits.
package countdown_timer_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_e;

    localparam digit_t BCD_NINE     = 4'd9;
    localparam digit_t SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/countdown_timer_bcd60_updown.sv
// Two-digit BCD up/down counter wrapping between 00 and MAX_VAL.
// Ports: clr/load/dec/inc controls (that priority), load_tens/load_ones,
// tens/ones digits, borrow_out (dec at 00), wrap_out (inc at MAX_VAL).
module bcd60_updown
    import countdown_timer_pkg::*;
#(
    parameter int MAX_VAL = 59
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   load,
    input  digit_t load_tens,
    input  digit_t load_ones,
    input  logic   inc,
    input  logic   dec,
    output digit_t tens,
    output digit_t ones,
    output logic   borrow_out,
    output logic   wrap_out
);

    localparam digit_t MAX_T = digit_t'(MAX_VAL / 10);
    localparam digit_t MAX_O = digit_t'(MAX_VAL % 10);

    digit_t tens_q, tens_d;
    digit_t ones_q, ones_d;
    logic   at_zero, at_max;

    assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign at_max  = (tens_q == MAX_T) && (ones_q == MAX_O);

    // Flags only fire when the step actually happens this cycle.
    assign borrow_out = !clr && !load && dec && at_zero;
    assign wrap_out   = !clr && !load && !dec && inc && at_max;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (load) begin
            tens_d = load_tens;
            ones_d = load_ones;
        end else if (dec) begin
            if (at_zero) begin
                tens_d = MAX_T;
                ones_d = MAX_O;
            end else if (ones_q == 4'd0) begin
                tens_d = tens_q - 4'd1;
                ones_d = BCD_NINE;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end else if (inc) begin
            if (at_max) begin
                tens_d = 4'd0;
                ones_d = 4'd0;
            end else if (ones_q == BCD_NINE) begin
                tens_d = tens_q + 4'd1;
                ones_d = 4'd0;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer with preset, pause/resume and timed alarm.
// Ports: clk, rst, tick_1hz, start, clr, min_inc, sec_inc in; four BCD
// digits (ten_m, one_m, ten_s, one_s), running and alarm out.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int ALARM_TICKS = 5,
    parameter int MAX_MIN     = 59
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   tick_1hz,
    input  logic   start,
    input  logic   clr,
    input  logic   min_inc,
    input  logic   sec_inc,
    output digit_t ten_m,
    output digit_t one_m,
    output digit_t ten_s,
    output digit_t one_s,
    output logic   running,
    output logic   alarm
);

    localparam int SEC_MAX = int'(SEC_TENS_MAX) * 10 + int'(BCD_NINE);
    localparam logic [3:0] ALARM_LAST = 4'(ALARM_TICKS - 1);

    state_e      state_q, state_d;
    logic [3:0]  acnt_q, acnt_d;
    logic [15:0] preset_q, preset_d;
    logic        running_q, running_d;
    logic        alarm_q, alarm_d;

    digit_t min_t, min_o, sec_t, sec_o;
    logic   cnt_clr, cnt_load;
    logic   sec_dec, sec_inc_en, min_inc_en;
    logic   sec_borrow, sec_wrap, min_borrow, min_wrap;
    logic   time_zero, time_one;
    logic   unused_flags;

    assign time_zero = ({min_t, min_o, sec_t, sec_o} == 16'h0000);
    assign time_one  = ({min_t, min_o, sec_t, sec_o} == 16'h0001);

    always_comb begin
        state_d    = state_q;
        acnt_d     = acnt_q;
        preset_d   = preset_q;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        sec_dec    = 1'b0;
        sec_inc_en = 1'b0;
        min_inc_en = 1'b0;
        if (clr) begin
            state_d = ST_IDLE;
            acnt_d  = 4'd0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !time_zero) begin
                        preset_d = {min_t, min_o, sec_t, sec_o};
                        state_d  = ST_RUN;
                    end else begin
                        sec_inc_en = sec_inc;
                        min_inc_en = min_inc;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        state_d = ST_PAUSE;
                    end else if (tick_1hz) begin
                        sec_dec = 1'b1;
                        // Last second lands on 00:00 and alarms on the same edge.
                        if (time_one) state_d = ST_ALARM;
                    end
                end
                ST_PAUSE: begin
                    if (start) state_d = ST_RUN;
                end
                ST_ALARM: begin
                    if (start) begin
                        state_d  = ST_IDLE;
                        cnt_load = 1'b1;
                        acnt_d   = 4'd0;
                    end else if (tick_1hz) begin
                        if (acnt_q == ALARM_LAST) begin
                            state_d  = ST_IDLE;
                            cnt_load = 1'b1;
                            acnt_d   = 4'd0;
                        end else begin
                            acnt_d = acnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_ALARM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acnt_q    <= 4'd0;
            preset_q  <= 16'h0000;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acnt_q    <= acnt_d;
            preset_q  <= preset_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

    bcd60_updown #(.MAX_VAL(SEC_MAX)) u_sec (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr),
        .load       (cnt_load),
        .load_tens  (preset_q[7:4]),
        .load_ones  (preset_q[3:0]),
        .inc        (sec_inc_en),
        .dec        (sec_dec),
        .tens       (sec_t),
        .ones       (sec_o),
        .borrow_out (sec_borrow),
        .wrap_out   (sec_wrap)
    );

    // Seconds borrow is the only source of minute decrements.
    bcd60_updown #(.MAX_VAL(MAX_MIN)) u_min (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr),
        .load       (cnt_load),
        .load_tens  (preset_q[15:12]),
        .load_ones  (preset_q[11:8]),
        .inc        (min_inc_en),
        .dec        (sec_borrow),
        .tens       (min_t),
        .ones       (min_o),
        .borrow_out (min_borrow),
        .wrap_out   (min_wrap)
    );

    // Seconds never carry into minutes; minute underflow cannot occur.
    assign unused_flags = sec_wrap ^ min_wrap ^ min_borrow;

    assign ten_m   = min_t;
    assign one_m   = min_o;
    assign ten_s   = sec_t;
    assign one_s   = sec_o;
    assign running = running_q;
    assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table plus scenario
// sequences, with expectations queued at drive time and checked after the edge.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       start = 1'b0;
    logic       clr = 1'b0;
    logic       min_inc = 1'b0;
    logic       sec_inc = 1'b0;
    logic [3:0] ten_m, one_m, ten_s, one_s;
    logic       running, alarm;

    int total = 0;
    int bad = 0;

    localparam logic [5:0] NON = 6'b000000;
    localparam logic [5:0] RST = 6'b100000;
    localparam logic [5:0] TCK = 6'b010000;
    localparam logic [5:0] STA = 6'b001000;
    localparam logic [5:0] CLR = 6'b000100;
    localparam logic [5:0] MIN = 6'b000010;
    localparam logic [5:0] SEC = 6'b000001;

    // o = {running, alarm}
    localparam logic [1:0] O_IDLE = 2'b00;
    localparam logic [1:0] O_RUN  = 2'b10;
    localparam logic [1:0] O_ALM  = 2'b01;

    typedef struct {
        logic [5:0]  in;
        logic [15:0] d;
        logic [1:0]  o;
        string       nm;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  o;
        string       nm;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    countdown_timer #(.ALARM_TICKS(5), .MAX_MIN(59)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .start    (start),
        .clr      (clr),
        .min_inc  (min_inc),
        .sec_inc  (sec_inc),
        .ten_m    (ten_m),
        .one_m    (one_m),
        .ten_s    (ten_s),
        .one_s    (one_s),
        .running  (running),
        .alarm    (alarm)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic vec_t mk(input logic [5:0] in, input logic [15:0] d,
                                input logic [1:0] o, input string nm);
        vec_t v;
        v.in = in;
        v.d  = d;
        v.o  = o;
        v.nm = nm;
        return v;
    endfunction

    task automatic step(input logic [5:0] in, input logic [15:0] ed,
                        input logic [1:0] eo, input string nm);
        exp_t e;
        logic [15:0] gd;
        logic [1:0]  go;
        @(negedge clk);
        {rst, tick_1hz, start, clr, min_inc, sec_inc} = in;
        e.d  = ed;
        e.o  = eo;
        e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        {rst, tick_1hz, start, clr, min_inc, sec_inc} = NON;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e  = sb.pop_front();
            gd = {ten_m, one_m, ten_s, one_s};
            go = {running, alarm};
            if (gd !== e.d || go !== e.o) begin
                bad++;
                $display("FAIL %s: got %h run/alm=%b, want %h run/alm=%b",
                         e.nm, gd, go, e.d, e.o);
            end
        end
    endtask

    task automatic preset(input int m, input int s);
        step(CLR, 16'h0000, O_IDLE, "preset clr");
        for (int i = 1; i <= m; i++)
            step(MIN, bcd(i, 0), O_IDLE, "preset min");
        for (int i = 1; i <= s; i++)
            step(SEC, bcd(m, i), O_IDLE, "preset sec");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back(mk(RST, 16'h0000, O_IDLE, "reset"));
        tbl.push_back(mk(MIN, 16'h0100, O_IDLE, "min 1"));
        tbl.push_back(mk(MIN, 16'h0200, O_IDLE, "min 2"));
        tbl.push_back(mk(MIN, 16'h0300, O_IDLE, "min 3"));
        tbl.push_back(mk(SEC, 16'h0301, O_IDLE, "sec 1"));
        tbl.push_back(mk(SEC, 16'h0302, O_IDLE, "sec 2"));
        tbl.push_back(mk(STA, 16'h0302, O_RUN,  "start run"));
        tbl.push_back(mk(MIN, 16'h0302, O_RUN,  "min ignored run"));
        tbl.push_back(mk(CLR, 16'h0000, O_IDLE, "clr run"));
        tbl.push_back(mk(STA, 16'h0000, O_IDLE, "start at zero"));
        tbl.push_back(mk(MIN | SEC, 16'h0101, O_IDLE, "min+sec"));
        tbl.push_back(mk(STA | MIN, 16'h0101, O_RUN, "start over min"));
        tbl.push_back(mk(TCK, 16'h0100, O_RUN,  "tick 0100"));
        tbl.push_back(mk(TCK, 16'h0059, O_RUN,  "tick borrow"));
        tbl.push_back(mk(RST, 16'h0000, O_IDLE, "reset in run"));
        tbl.push_back(mk(TCK, 16'h0000, O_IDLE, "tick after rst"));

        foreach (tbl[i])
            step(tbl[i].in, tbl[i].d, tbl[i].o, tbl[i].nm);

        // 01:00 down to alarm, then timed return with preset reload
        preset(1, 0);
        step(STA, 16'h0100, O_RUN, "start 0100");
        step(TCK, 16'h0059, O_RUN, "tick 0059");
        for (int k = 58; k >= 0; k--)
            step(TCK, bcd(0, k), (k == 0) ? O_ALM : O_RUN, "countdown");
        for (int k = 1; k <= 4; k++)
            step(TCK, 16'h0000, O_ALM, "alarm hold");
        step(TCK, 16'h0100, O_IDLE, "alarm expire reload");
        step(SEC, 16'h0101, O_IDLE, "idle after alarm");

        // 00:01: alarm on the same edge; only ticks are counted
        preset(0, 1);
        step(STA, 16'h0001, O_RUN, "start 0001");
        step(TCK, 16'h0000, O_ALM, "alarm same edge");
        for (int k = 1; k <= 4; k++) begin
            step(NON, 16'h0000, O_ALM, "alarm no tick");
            step(TCK, 16'h0000, O_ALM, "alarm count");
        end
        step(TCK, 16'h0001, O_IDLE, "alarm reload 0001");

        // pause/resume
        preset(0, 10);
        step(STA, 16'h0010, O_RUN, "start 0010");
        step(STA | TCK, 16'h0010, O_IDLE, "pause beats tick");
        for (int k = 0; k < 5; k++)
            step(TCK, 16'h0010, O_IDLE, "paused tick");
        step(MIN, 16'h0010, O_IDLE, "min ignored pause");
        step(STA, 16'h0010, O_RUN, "resume");
        step(TCK, 16'h0009, O_RUN, "tick after resume");

        // seconds wrap without carry, minute wrap at MAX_MIN
        step(CLR, 16'h0000, O_IDLE, "clr");
        step(STA, 16'h0000, O_IDLE, "start zero ignored");
        step(MIN, 16'h0100, O_IDLE, "min to 01");
        for (int s = 1; s <= 60; s++)
            step(SEC, bcd(1, s % 60), O_IDLE, "sec sweep");
        for (int m = 2; m <= 59; m++)
            step(MIN, bcd(m, 0), O_IDLE, "min sweep");
        step(MIN, 16'h0000, O_IDLE, "min wrap");

        // reset while running at 02:30
        preset(2, 30);
        step(STA, 16'h0230, O_RUN, "start 0230");
        step(RST, 16'h0000, O_IDLE, "rst in run");
        step(TCK, 16'h0000, O_IDLE, "idle after rst");

        // clr in alarm: no reload
        preset(0, 1);
        step(STA, 16'h0001, O_RUN, "start 0001 b");
        step(TCK, 16'h0000, O_ALM, "alarm b");
        step(CLR, 16'h0000, O_IDLE, "clr in alarm");
        step(TCK, 16'h0000, O_IDLE, "no reload after clr");

        // start acknowledges alarm with reload
        preset(0, 2);
        step(STA, 16'h0002, O_RUN, "start 0002");
        step(TCK, 16'h0001, O_RUN, "tick 0001");
        step(TCK, 16'h0000, O_ALM, "alarm c");
        step(STA, 16'h0002, O_IDLE, "ack reload");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Count-down counterpart of the up-counting stopwatch: the user presets MM:SS with button pulses, starts the timer, and it decrements once per 1 Hz tick to 00:00, then raises an alarm. Outputs are four BCD digits, matching what the existing decoder/display chain consumes, so the block drops into the same top level in place of the up-counter. Button inputs arrive already debounced and one-pulsed; the tick comes from the existing frequency divider as a one-cycle enable.

Parameters:
ALARM_TICKS, 5, number of tick_1hz pulses the alarm output stays high before auto-return to IDLE (1..15)
MAX_MIN, 59, highest settable minute value (BCD wrap point for minute preset, 1..99)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
tick_1hz  input  1  one-cycle enable pulse, once per second
start  input  1  one-cycle pulse: start / pause / resume / acknowledge alarm
clr  input  1  one-cycle pulse: abort and return to IDLE with 00:00
min_inc  input  1  one-cycle pulse: preset minutes +1 (IDLE only)
sec_inc  input  1  one-cycle pulse: preset seconds +1 (IDLE only)
ten_m  output  4  BCD minutes tens
one_m  output  4  BCD minutes ones
ten_s  output  4  BCD seconds tens
one_s  output  4  BCD seconds ones
running  output  1  high in RUN state
alarm  output  1  high in ALARM state

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Reset forces state=IDLE, all digits 0, preset register 00:00, running=0, alarm=0, alarm tick count 0.
- All outputs are registered. A change is visible one clk after the causing input cycle.
- States: IDLE, RUN, PAUSE, ALARM.
- IDLE:
  - min_inc increments minutes in BCD, wrapping MAX_MIN->00.
  - sec_inc increments seconds in BCD, wrapping 59->00 with no carry into minutes.
  - min_inc and sec_inc in the same cycle both apply.
  - start with time != 00:00: copy time into the preset register and go to RUN.
  - start with time == 00:00: ignored.
- RUN:
  - Each tick_1hz decrements MM:SS in BCD. Seconds borrow: 00 -> 59 with minutes-1.
  - A tick when time is 00:01 writes 00:00 and enters ALARM on the same edge.
  - start goes to PAUSE.
  - clr goes to IDLE with 00:00.
- PAUSE: time is frozen and ticks are ignored. start goes to RUN; clr goes to IDLE with 00:00.
- ALARM:
  - alarm=1 and digits show 00:00.
  - The internal counter counts tick_1hz. At the ALARM_TICKS-th tick, go to IDLE and reload the digits from the preset register.
  - start also goes to IDLE with the preset reloaded.
  - clr goes to IDLE with 00:00.
- Priority within one cycle: rst > clr > start > tick_1hz > min_inc/sec_inc.
  - Example: start and tick together in RUN gives PAUSE with no decrement.
- min_inc and sec_inc are ignored outside IDLE.
- Digits are always valid BCD (0-9, tens of seconds 0-5). Out-of-range values are unreachable.

Decomposition:
- Shared package holds:
  - the state enum (IDLE=0, RUN=1, PAUSE=2, ALARM=3, 2-bit),
  - BCD constants (BCD_NINE, SEC_TENS_MAX=5),
  - a 4-bit digit typedef used by the decoder and display as well.
- One sub-module, bcd60_updown: a two-digit BCD counter with inc, dec, load and clear inputs, a parameterised max value, and borrow/wrap outputs. It is instantiated twice, once for seconds (max 59) and once for minutes (max MAX_MIN). Seconds borrow_out drives minutes dec.
- The FSM and alarm tick counter live in countdown_timer.

Test Plan:
1. Reset, then 3x min_inc and 2x sec_inc -> digits 0,3,0,2. Then start -> running=1 on the next clk.
2. Preset 01:00, start, 1 tick -> 00:59. 59 more ticks -> 00:00 with alarm=1, running=0.
3. Preset 00:01, start, 1 tick -> ALARM on the same edge. ALARM_TICKS ticks later -> alarm=0, IDLE, digits reload to 00:01.
4. RUN at 00:10, start and tick in the same cycle -> PAUSE, digits stay 00:10. 5 ticks -> still 00:10. start -> RUN. Next tick -> 00:09.
5. IDLE 00:00, start -> stays IDLE with running=0. 60 sec_inc pulses -> back to 00:00 with minutes unchanged.
6. RUN at 02:30, assert rst for one cycle -> next clk all digits 0, IDLE, alarm=0. Separately, clr in ALARM -> IDLE with 00:00 and no preset reload.
